// File: rtl/pmp_pkg.sv
// Shared PMP CSR definitions: CSR numbers, A-field and op encodings, cfg byte layout.
package pmp_pkg;

    localparam logic [11:0] PMPCFG0  = 12'h3A0;
    localparam logic [11:0] PMPCFG1  = 12'h3A1;
    localparam logic [11:0] PMPADDR0 = 12'h3B0;

    typedef enum logic [1:0] {
        A_OFF   = 2'd0,
        A_TOR   = 2'd1,
        A_NA4   = 2'd2,
        A_NAPOT = 2'd3
    } pmp_a_e;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_a_e     a;
        logic       x;
        logic       w;
        logic       r;
    } pmp_cfg_t;

    // Raw CSR read-modify-write result before any field legalisation.
    function automatic logic [31:0] apply_op(csr_op_e op, logic [31:0] old_v, logic [31:0] operand);
        logic [31:0] res;
        case (op)
            OP_WRITE: res = operand;
            OP_SET:   res = old_v | operand;
            OP_CLEAR: res = old_v & ~operand;
            default:  res = old_v;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pmp_cfg_legalize.sv
// Combinational next-value for one PMP cfg byte: op, WARL legalisation, lock.
module pmp_cfg_legalize
    import pmp_pkg::*;
#(
    parameter int unsigned GRAN_LOG2 = 2
) (
    input  logic [7:0] old_cfg,
    input  logic [1:0] op,
    input  logic [7:0] operand,
    output logic [7:0] new_cfg
);

    pmp_cfg_t old_c;
    pmp_cfg_t raw;
    pmp_cfg_t legal;

    always_comb begin
        old_c = pmp_cfg_t'(old_cfg);
        raw   = pmp_cfg_t'(8'(apply_op(csr_op_e'(op), {24'h0, old_cfg}, {24'h0, operand})));

        legal      = raw;
        legal.rsvd = '0;
        if (!legal.r && legal.w) begin
            legal.w = 1'b0;
        end
        // NA4 is not representable when the granule exceeds 4 bytes; keep the old mode.
        if ((GRAN_LOG2 > 2) && (legal.a == A_NA4)) begin
            legal.a = old_c.a;
        end

        new_cfg = old_c.l ? old_cfg : legal;
    end

endmodule

// File: rtl/pmp_csr_file.sv
// Machine-mode PMP CSR file: pmpcfg0/1 and pmpaddr0..N-1 with WARL and lock handling,
// registered read port and a change strobe for downstream grant caches.
module pmp_csr_file
    import pmp_pkg::*;
#(
    parameter int unsigned ENTRIES   = 8,
    parameter int unsigned ADDR_W    = 30,
    parameter int unsigned GRAN_LOG2 = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                csr_op,
    input  logic [11:0]               csr_addr,
    input  logic [31:0]               csr_wdata,
    input  logic                      csr_ren,
    output logic [31:0]               csr_rdata,
    output logic                      csr_rvalid,
    output logic                      csr_illegal,
    output logic [ENTRIES*8-1:0]      pmp_cfg,
    output logic [ENTRIES*ADDR_W-1:0] pmp_addr,
    output logic                      cfg_changed
);

    // Low pmpaddr bits that are implied by the granule and only affect read-back.
    localparam logic [ADDR_W-1:0] G_MASK = ADDR_W'((64'd1 << (GRAN_LOG2 - 2)) - 64'd1);

    pmp_cfg_t [ENTRIES-1:0]             cfg_q;
    pmp_cfg_t [ENTRIES-1:0]             cfg_d;
    pmp_cfg_t [7:0]                     cfg_pad;
    logic     [ENTRIES-1:0][ADDR_W-1:0] addr_q;
    logic     [ENTRIES-1:0][ADDR_W-1:0] addr_d;
    logic     [ENTRIES-1:0]             addr_lock;

    csr_op_e     op;
    logic        is_cfg0;
    logic        is_cfg1;
    logic        is_addr;
    logic        csr_bad;
    logic [31:0] rd_data;

    assign op = csr_op_e'(csr_op);

    always_comb begin
        is_cfg0 = (csr_addr == PMPCFG0);
        is_cfg1 = (csr_addr == PMPCFG1);
        is_addr = (csr_addr[11:4] == PMPADDR0[11:4]);
        csr_bad = !(is_cfg0 || is_cfg1 || is_addr);
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_cfg
        logic [1:0] ent_op;

        assign ent_op = (((i < 4) ? is_cfg0 : is_cfg1)) ? csr_op : OP_NONE;

        pmp_cfg_legalize #(
            .GRAN_LOG2(GRAN_LOG2)
        ) u_legalize (
            .old_cfg (cfg_q[i]),
            .op      (ent_op),
            .operand (csr_wdata[8*(i%4) +: 8]),
            .new_cfg (cfg_d[i])
        );
    end

    // An address is frozen by its own lock, or by the next entry locked in TOR mode.
    always_comb begin
        addr_lock = '0;
        for (int unsigned i = 0; i + 1 < ENTRIES; i++) begin
            addr_lock[i] = cfg_q[i].l | (cfg_q[i+1].l & (cfg_q[i+1].a == A_TOR));
        end
        addr_lock[ENTRIES-1] = cfg_q[ENTRIES-1].l;
    end

    always_comb begin
        addr_d = addr_q;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (is_addr && (csr_addr[3:0] == 4'(i)) && !addr_lock[i]) begin
                addr_d[i] = ADDR_W'(apply_op(op, 32'(addr_q[i]), csr_wdata));
            end
        end
    end

    always_comb begin
        cfg_pad = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            cfg_pad[i] = cfg_q[i];
        end

        rd_data = '0;
        if (is_cfg0) begin
            rd_data = cfg_pad[3:0];
        end else if (is_cfg1) begin
            rd_data = cfg_pad[7:4];
        end else if (is_addr) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (csr_addr[3:0] == 4'(i)) begin
                    case (cfg_q[i].a)
                        A_NAPOT:      rd_data = 32'(addr_q[i] | G_MASK);
                        A_OFF, A_TOR: rd_data = 32'(addr_q[i] & ~G_MASK);
                        default:      rd_data = 32'(addr_q[i]);
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_q       <= '0;
            addr_q      <= '0;
            csr_rdata   <= '0;
            csr_rvalid  <= 1'b0;
            csr_illegal <= 1'b0;
            cfg_changed <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            addr_q      <= addr_d;
            cfg_changed <= (cfg_d != cfg_q) || (addr_d != addr_q);
            csr_rvalid  <= csr_ren && !csr_bad;
            csr_illegal <= csr_bad && (csr_ren || (op != OP_NONE));
            if (csr_ren && !csr_bad) begin
                csr_rdata <= rd_data;
            end
        end
    end

    assign pmp_cfg  = cfg_q;
    assign pmp_addr = addr_q;

endmodule

// File: tb/tb_pmp_csr_file.sv
// Scoreboard bench for pmp_csr_file: directed CSR ops queue expectations, a monitor checks them.
module tb_pmp_csr_file;
    import pmp_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_ren;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        csr_illegal;
    logic [63:0] pmp_cfg;
    logic [239:0] pmp_addr;
    logic        cfg_changed;

    always #5 clock = ~clock;

    pmp_csr_file #(
        .ENTRIES   (8),
        .ADDR_W    (30),
        .GRAN_LOG2 (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .csr_op      (csr_op),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_ren     (csr_ren),
        .csr_rdata   (csr_rdata),
        .csr_rvalid  (csr_rvalid),
        .csr_illegal (csr_illegal),
        .pmp_cfg     (pmp_cfg),
        .pmp_addr    (pmp_addr),
        .cfg_changed (cfg_changed)
    );

    typedef struct {
        int          due;
        bit          ill;
        bit          chg;
        bit          rdv;
        bit          cc;
        logic [31:0] cfgx;
        int          ai;
        logic [29:0] ax;
        bit          rk;
        logic [31:0] rh;
    } exp_t;

    exp_t        pq[$];
    logic [31:0] rdq[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    bit          rst_nx = 1'b1;
    bit          w_cc = 1'b0;
    logic [31:0] w_cfg = '0;
    int          w_ai = -1;
    logic [29:0] w_ax = '0;
    bit          w_rk = 1'b0;
    logic [31:0] w_rh = '0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic want_cfg(input logic [31:0] v);
        w_cc  = 1'b1;
        w_cfg = v;
    endtask

    task automatic want_addr(input int i, input logic [29:0] v);
        w_ai = i;
        w_ax = v;
    endtask

    task automatic want_rdata(input logic [31:0] v);
        w_rk = 1'b1;
        w_rh = v;
    endtask

    task automatic step(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d,
                        input logic ren, input bit ill, input bit chg, input logic [31:0] rdx);
        exp_t e;
        @(posedge clock);
        #1;
        reset     = rst_nx;
        csr_op    = op;
        csr_addr  = a;
        csr_wdata = d;
        csr_ren   = ren;
        e.due  = cyc + 1;
        e.ill  = ill;
        e.chg  = chg;
        e.rdv  = ren && !ill && !rst_nx;
        e.cc   = w_cc;
        e.cfgx = w_cfg;
        e.ai   = w_ai;
        e.ax   = w_ax;
        e.rk   = w_rk;
        e.rh   = w_rh;
        if (e.rdv) rdq.push_back(rdx);
        pq.push_back(e);
        w_cc = 1'b0;
        w_ai = -1;
        w_rk = 1'b0;
    endtask

    task automatic idle();
        step(OP_NONE, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    always @(negedge clock) begin
        if (csr_rvalid) begin
            if (rdq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_unexpected: got rvalid=1 rdata=%h expected no read (cycle %0d)", csr_rdata, cyc);
            end else begin
                check("rdata", csr_rdata, rdq.pop_front());
            end
        end
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            mon_e = pq.pop_front();
            check("illegal", 32'(csr_illegal), 32'(mon_e.ill));
            check("changed", 32'(cfg_changed), 32'(mon_e.chg));
            check("rvalid", 32'(csr_rvalid), 32'(mon_e.rdv));
            if (mon_e.cc) check("pmp_cfg_lo", pmp_cfg[31:0], mon_e.cfgx);
            if (mon_e.ai >= 0) check("pmp_addr", 32'(pmp_addr[mon_e.ai*30 +: 30]), 32'(mon_e.ax));
            if (mon_e.rk) check("rdata_hold", csr_rdata, mon_e.rh);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        csr_op    = OP_NONE;
        csr_addr  = '0;
        csr_wdata = '0;
        csr_ren   = 1'b0;

        rst_nx = 1'b1;
        repeat (3) idle();
        rst_nx = 1'b0;
        want_cfg(32'h0); want_addr(0, 30'h0); want_rdata(32'h0);
        idle();

        step(OP_NONE,  12'h3A0, 32'h0, 1'b1, 0, 0, 32'h0000_0000);
        want_cfg(32'h0000_0000);
        step(OP_WRITE, 12'h3A0, 32'h0000_0002, 1'b0, 0, 0, 32'h0);
        want_cfg(32'h0000_001F);
        step(OP_WRITE, 12'h3A0, 32'h0000_001F, 1'b0, 0, 1, 32'h0);
        want_cfg(32'h0000_001F);
        step(OP_WRITE, 12'h3A0, 32'h0000_001F, 1'b0, 0, 0, 32'h0);
        step(OP_NONE,  12'h3A0, 32'h0, 1'b1, 0, 0, 32'h0000_001F);
        want_cfg(32'h0000_0004);
        step(OP_WRITE, 12'h3A0, 32'h0000_0066, 1'b0, 0, 1, 32'h0);

        // Entry 1 locked in TOR mode freezes pmpaddr0 and pmpaddr1.
        want_cfg(32'h0000_8800);
        step(OP_WRITE, 12'h3A0, 32'h0000_8800, 1'b0, 0, 1, 32'h0);
        want_addr(0, 30'h0);
        step(OP_WRITE, 12'h3B0, 32'h1234_5678, 1'b0, 0, 0, 32'h0);
        want_addr(1, 30'h0);
        step(OP_WRITE, 12'h3B1, 32'h0000_00FF, 1'b0, 0, 0, 32'h0);
        want_addr(2, 30'h0000_1000);
        step(OP_WRITE, 12'h3B2, 32'h0000_1000, 1'b0, 0, 1, 32'h0);
        want_addr(2, 30'h0000_1003);
        step(OP_SET,   12'h3B2, 32'h0000_0003, 1'b0, 0, 1, 32'h0);
        want_addr(2, 30'h0000_0003);
        step(OP_CLEAR, 12'h3B2, 32'h0000_1000, 1'b0, 0, 1, 32'h0);
        want_addr(4, 30'h3FFF_FFFF);
        step(OP_WRITE, 12'h3B4, 32'hFFFF_FFFF, 1'b0, 0, 1, 32'h0);
        step(OP_NONE,  12'h3B4, 32'h0, 1'b1, 0, 0, 32'h3FFF_FFFF);

        want_cfg(32'h0F0F_8880);
        step(OP_SET,   12'h3A0, 32'h0F0F_0080, 1'b0, 0, 1, 32'h0);
        want_cfg(32'h0000_8880);
        step(OP_CLEAR, 12'h3A0, 32'hFFFF_FFFF, 1'b0, 0, 1, 32'h0);
        want_cfg(32'h0000_8880);
        step(OP_WRITE, 12'h3A0, 32'h0000_0000, 1'b0, 0, 0, 32'h0);

        step(OP_WRITE, 12'h3A1, 32'h0000_0019, 1'b0, 0, 1, 32'h0);
        step(OP_NONE,  12'h3A1, 32'h0, 1'b1, 0, 0, 32'h0000_0019);

        step(OP_NONE,  12'h3A2, 32'h0, 1'b1, 1, 0, 32'h0);
        step(OP_WRITE, 12'h3A3, 32'h0000_0001, 1'b0, 1, 0, 32'h0);
        step(OP_SET,   12'h340, 32'h0000_0001, 1'b0, 1, 0, 32'h0);
        step(OP_NONE,  12'h3BF, 32'h0, 1'b1, 0, 0, 32'h0000_0000);

        want_addr(3, 30'h55);
        step(OP_WRITE, 12'h3B3, 32'h0000_0055, 1'b1, 0, 1, 32'h0000_0000);
        step(OP_NONE,  12'h3B3, 32'h0, 1'b1, 0, 0, 32'h0000_0055);
        want_rdata(32'h0000_0055);
        idle();

        rst_nx = 1'b1;
        step(OP_WRITE, 12'h3B5, 32'h0000_0077, 1'b1, 0, 0, 32'h0);
        step(OP_SET,   12'h3A2, 32'h0000_0001, 1'b1, 0, 0, 32'h0);
        rst_nx = 1'b0;
        want_cfg(32'h0); want_addr(5, 30'h0); want_rdata(32'h0);
        idle();
        want_cfg(32'h0000_0007);
        step(OP_WRITE, 12'h3A0, 32'h0000_0007, 1'b0, 0, 1, 32'h0);
        repeat (3) idle();

        for (int k = 0; k < 20 && pq.size() > 0; k++) @(negedge clock);
        #1;
        check("pending_pulses", 32'(pq.size()), 32'h0);
        check("pending_reads", 32'(rdq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
